mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, RAM port status and the memory arbiter state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    // Data grants in a row (with the instruction side waiting) before fetch wins.
    localparam logic [1:0] STARVE_MAX = 2'd3;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one RAM port between instruction fetch and data.
// Data normally wins; after three data completions in a row while fetch is
// waiting, fetch gets the next grant. Every grant is followed by an IDLE bubble.
module mem_arbiter
    import cpu_types_pkg::*;
(
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    input  ramstate_t ramstate,
    input  word_t     ramload,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    output logic      merr
);

    arb_state_t state_q, state_d;
    logic [1:0] starve_q, starve_d;
    logic       merr_q, merr_d;

    logic d_req;
    logic starve_active;

    assign d_req         = dREN | dWEN;
    assign starve_active = (starve_q == STARVE_MAX);
    assign merr          = merr_q;

    // Next-state, starvation counter and sticky error flag.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        merr_d   = merr_q;
        case (state_q)
            IDLE: begin
                if (d_req && !(starve_active && iREN)) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end
            DGRANT: begin
                if (!d_req) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    state_d = IDLE;
                    if (iREN && !starve_active) begin
                        starve_d = starve_q + 2'd1;
                    end
                end else if (ramstate == ERROR) begin
                    state_d = IDLE;
                    merr_d  = 1'b1;
                end
            end
            IGRANT: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    state_d  = IDLE;
                    starve_d = '0;
                end else if (ramstate == ERROR) begin
                    state_d = IDLE;
                    merr_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!iREN) begin
            starve_d = '0;
        end
    end

    // State registers with synchronous reset that wins over any transaction.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            merr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            merr_q   <= merr_d;
        end
    end

    // RAM port and requester outputs; reset forces the IDLE values immediately.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        if (!RST) begin
            case (state_q)
                DGRANT: begin
                    ramREN   = dREN;
                    ramWEN   = dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (d_req && ramstate == ACCESS) begin
                        dwait = 1'b0;
                        dload = ramload;
                    end
                end
                IGRANT: begin
                    ramREN  = iREN;
                    ramaddr = iaddr;
                    if (iREN && ramstate == ACCESS) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a directed cycle table, hand-written
// multi-cycle scenarios and a randomized run against a transaction-level model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam word_t IA = 32'h0000_0200;
    localparam word_t DA = 32'h0000_0100;
    localparam word_t DS = 32'h55AA_55AA;

    typedef struct packed {
        logic      rst;
        logic      iren;
        logic      dren;
        logic      dwen;
        ramstate_t rs;
        word_t     load;
    } vin_t;

    typedef struct packed {
        logic  ramren;
        logic  ramwen;
        word_t ramaddr;
        word_t ramstore;
        logic  iwait;
        logic  dwait;
        word_t iload;
        word_t dload;
        logic  merr;
    } vout_t;

    typedef struct packed {
        vin_t  in;
        vout_t out;
    } vec_t;

    logic      CLK;
    logic      RST;
    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    ramstate_t ramstate;
    word_t     ramload;
    logic      iwait;
    logic      dwait;
    word_t     iload;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    logic      merr;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .ramstate (ramstate),
        .ramload  (ramload),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .merr     (merr)
    );

    // Free-running 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(logic rst, logic iren, logic dren, logic dwen, ramstate_t rs,
                                word_t load, logic ren, logic wen, word_t addr, word_t store,
                                logic iw, logic dw, word_t il, word_t dl, logic me);
        vec_t v;
        v.in  = '{rst: rst, iren: iren, dren: dren, dwen: dwen, rs: rs, load: load};
        v.out = '{ramren: ren, ramwen: wen, ramaddr: addr, ramstore: store,
                  iwait: iw, dwait: dw, iload: il, dload: dl, merr: me};
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the clock edge and wait for them to settle.
    task automatic applyStimulus(input vin_t v, input word_t ia, input word_t da, input word_t ds);
        RST      = v.rst;
        iREN     = v.iren;
        dREN     = v.dren;
        dWEN     = v.dwen;
        ramstate = v.rs;
        ramload  = v.load;
        iaddr    = ia;
        daddr    = da;
        dstore   = ds;
        @(negedge CLK);
    endtask

    task automatic advance();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input vout_t e);
        cmp({tag, ".ramREN"},   32'(ramREN),   32'(e.ramren));
        cmp({tag, ".ramWEN"},   32'(ramWEN),   32'(e.ramwen));
        cmp({tag, ".ramaddr"},  ramaddr,       e.ramaddr);
        cmp({tag, ".ramstore"}, ramstore,      e.ramstore);
        cmp({tag, ".iwait"},    32'(iwait),    32'(e.iwait));
        cmp({tag, ".dwait"},    32'(dwait),    32'(e.dwait));
        cmp({tag, ".iload"},    iload,         e.iload);
        cmp({tag, ".dload"},    dload,         e.dload);
        cmp({tag, ".merr"},     32'(merr),     32'(e.merr));
    endtask

    function automatic vin_t vi(logic rst, logic iren, logic dren, logic dwen, ramstate_t rs, word_t load);
        vin_t v;
        v = '{rst: rst, iren: iren, dren: dren, dwen: dwen, rs: rs, load: load};
        return v;
    endfunction

    // Reference model: who currently owns the RAM port, how many data
    // completions fetch has sat through, and whether any RAM error was seen.
    localparam int OWNER_NONE  = 0;
    localparam int OWNER_DATA  = 1;
    localparam int OWNER_INSTR = 2;
    int m_owner    = OWNER_NONE;
    int m_skipped  = 0;
    bit m_err_seen = 1'b0;

    function automatic vout_t model_expect(vin_t v, word_t ia, word_t da, word_t ds);
        vout_t e;
        bit asking;
        e = '{ramren: 1'b0, ramwen: 1'b0, ramaddr: 32'h0, ramstore: 32'h0,
              iwait: 1'b1, dwait: 1'b1, iload: 32'h0, dload: 32'h0, merr: m_err_seen};
        if (v.rst) return e;
        if (m_owner == OWNER_DATA) begin
            asking     = v.dren || v.dwen;
            e.ramren   = v.dren;
            e.ramwen   = v.dwen;
            e.ramaddr  = da;
            e.ramstore = ds;
            if (asking && v.rs == ACCESS) begin
                e.dwait = 1'b0;
                e.dload = v.load;
            end
        end else if (m_owner == OWNER_INSTR) begin
            e.ramren  = v.iren;
            e.ramaddr = ia;
            if (v.iren && v.rs == ACCESS) begin
                e.iwait = 1'b0;
                e.iload = v.load;
            end
        end
        return e;
    endfunction

    task automatic model_advance(input vin_t v);
        bit asking;
        if (v.rst) begin
            m_owner    = OWNER_NONE;
            m_skipped  = 0;
            m_err_seen = 1'b0;
            return;
        end
        if (m_owner == OWNER_NONE) begin
            if ((v.dren || v.dwen) && !(m_skipped >= 3 && v.iren)) m_owner = OWNER_DATA;
            else if (v.iren) m_owner = OWNER_INSTR;
        end else begin
            asking = (m_owner == OWNER_DATA) ? (v.dren || v.dwen) : v.iren;
            if (!asking) begin
                m_owner = OWNER_NONE;
            end else if (v.rs == ACCESS) begin
                if (m_owner == OWNER_DATA) m_skipped = (m_skipped + 1 > 3) ? 3 : m_skipped + 1;
                else m_skipped = 0;
                m_owner = OWNER_NONE;
            end else if (v.rs == ERROR) begin
                m_err_seen = 1'b1;
                m_owner    = OWNER_NONE;
            end
        end
        if (!v.iren) m_skipped = 0;
    endtask

    vec_t vecs[17];

    initial begin
        vin_t  v;
        vout_t e;
        word_t ia, da, ds;
        int    dsel;

        // Cycle-by-cycle table: reset, data read, simultaneous requests, abort.
        vecs[0]  = mk(H,L,L,L,FREE,  32'h0,        L,L,32'h0,32'h0, H,H,32'h0,32'h0,L);
        vecs[1]  = mk(L,L,H,L,FREE,  32'h0,        L,L,32'h0,32'h0, H,H,32'h0,32'h0,L);
        vecs[2]  = mk(L,L,H,L,BUSY,  32'h0,        H,L,DA,   DS,    H,H,32'h0,32'h0,L);
        vecs[3]  = mk(L,L,H,L,BUSY,  32'h0,        H,L,DA,   DS,    H,H,32'h0,32'h0,L);
        vecs[4]  = mk(L,L,H,L,ACCESS,32'hDEADBEEF, H,L,DA,   DS,    H,L,32'h0,32'hDEADBEEF,L);
        vecs[5]  = mk(L,L,L,L,FREE,  32'hDEADBEEF, L,L,32'h0,32'h0, H,H,32'h0,32'h0,L);
        vecs[6]  = mk(L,H,L,H,FREE,  32'h0,        L,L,32'h0,32'h0, H,H,32'h0,32'h0,L);
        vecs[7]  = mk(L,H,L,H,BUSY,  32'h0,        L,H,DA,   DS,    H,H,32'h0,32'h0,L);
        vecs[8]  = mk(L,H,L,H,ACCESS,32'h12345678, L,H,DA,   DS,    H,L,32'h0,32'h12345678,L);
        vecs[9]  = mk(L,H,L,L,FREE,  32'h0,        L,L,32'h0,32'h0, H,H,32'h0,32'h0,L);
        vecs[10] = mk(L,H,L,L,BUSY,  32'h0,        H,L,IA,   32'h0, H,H,32'h0,32'h0,L);
        vecs[11] = mk(L,H,L,L,ACCESS,32'hCAFEF00D, H,L,IA,   32'h0, L,H,32'hCAFEF00D,32'h0,L);
        vecs[12] = mk(L,L,L,L,FREE,  32'h0,        L,L,32'h0,32'h0, H,H,32'h0,32'h0,L);
        vecs[13] = mk(L,L,H,L,FREE,  32'h0,        L,L,32'h0,32'h0, H,H,32'h0,32'h0,L);
        vecs[14] = mk(L,L,H,L,BUSY,  32'h0,        H,L,DA,   DS,    H,H,32'h0,32'h0,L);
        vecs[15] = mk(L,L,L,L,BUSY,  32'h0,        L,L,DA,   DS,    H,H,32'h0,32'h0,L);
        vecs[16] = mk(L,L,L,L,ACCESS,32'h11111111, L,L,32'h0,32'h0, H,H,32'h0,32'h0,L);

        applyStimulus(vi(H,L,L,L,FREE,32'h0), IA, DA, DS);
        advance();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].in, IA, DA, DS);
            checkOutput($sformatf("vec%0d", i), vecs[i].out);
            advance();
        end

        // Starvation: fetch held high while data requests keep arriving.
        applyStimulus(vi(H,L,L,L,FREE,32'h0), IA, DA, DS);
        advance();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(vi(L,H,H,L,FREE,32'h0), IA, DA, DS);
            cmp($sformatf("starve%0d.idle_ramREN", k), 32'(ramREN), 32'h0);
            advance();
            applyStimulus(vi(L,H,H,L,ACCESS,32'hA0 + 32'(k)), IA, DA, DS);
            cmp($sformatf("starve%0d.ramaddr", k), ramaddr, DA);
            cmp($sformatf("starve%0d.dwait", k), 32'(dwait), 32'h0);
            cmp($sformatf("starve%0d.iwait", k), 32'(iwait), 32'h1);
            cmp($sformatf("starve%0d.dload", k), dload, 32'hA0 + 32'(k));
            advance();
        end
        applyStimulus(vi(L,H,H,L,FREE,32'h0), IA, DA, DS);
        cmp("starve.bubble_ramREN", 32'(ramREN), 32'h0);
        advance();
        applyStimulus(vi(L,H,H,L,BUSY,32'h0), IA, DA, DS);
        cmp("starve.igrant_ramaddr", ramaddr, IA);
        cmp("starve.igrant_ramREN", 32'(ramREN), 32'h1);
        cmp("starve.igrant_dwait", 32'(dwait), 32'h1);
        advance();
        applyStimulus(vi(L,H,H,L,ACCESS,32'hB0B0B0B0), IA, DA, DS);
        cmp("starve.igrant_iwait", 32'(iwait), 32'h0);
        cmp("starve.igrant_iload", iload, 32'hB0B0B0B0);
        advance();
        applyStimulus(vi(L,H,H,L,FREE,32'h0), IA, DA, DS);
        advance();
        applyStimulus(vi(L,H,H,L,BUSY,32'h0), IA, DA, DS);
        cmp("starve.cleared_ramaddr", ramaddr, DA);
        advance();
        applyStimulus(vi(L,H,H,L,ACCESS,32'h0), IA, DA, DS);
        advance();

        // Error during a fetch grant, retry, sticky flag, then reset mid-fetch.
        applyStimulus(vi(L,H,L,L,FREE,32'h0), IA, DA, DS);
        advance();
        applyStimulus(vi(L,H,L,L,ERROR,32'h0), IA, DA, DS);
        cmp("err.iwait", 32'(iwait), 32'h1);
        cmp("err.ramREN", 32'(ramREN), 32'h1);
        advance();
        applyStimulus(vi(L,H,L,L,FREE,32'h0), IA, DA, DS);
        cmp("err.merr_set", 32'(merr), 32'h1);
        cmp("err.idle_ramREN", 32'(ramREN), 32'h0);
        advance();
        applyStimulus(vi(L,H,L,L,ACCESS,32'h600DF00D), IA, DA, DS);
        cmp("err.retry_iwait", 32'(iwait), 32'h0);
        cmp("err.retry_iload", iload, 32'h600DF00D);
        advance();
        applyStimulus(vi(L,H,L,L,FREE,32'h0), IA, DA, DS);
        cmp("err.merr_sticky", 32'(merr), 32'h1);
        advance();
        applyStimulus(vi(L,H,L,L,BUSY,32'h0), IA, DA, DS);
        cmp("rst.pre_ramREN", 32'(ramREN), 32'h1);
        advance();
        applyStimulus(vi(H,H,L,L,BUSY,32'h0), IA, DA, DS);
        cmp("rst.during_ramREN", 32'(ramREN), 32'h0);
        cmp("rst.during_iwait", 32'(iwait), 32'h1);
        advance();
        applyStimulus(vi(L,H,L,L,BUSY,32'h0), IA, DA, DS);
        cmp("rst.after_ramREN", 32'(ramREN), 32'h0);
        cmp("rst.after_merr", 32'(merr), 32'h0);
        advance();

        // Randomized traffic against the transaction-level model.
        m_owner = OWNER_NONE;
        m_skipped = 0;
        m_err_seen = 1'b0;
        v = vi(H,L,L,L,FREE,32'h0);
        for (int i = 0; i < 400; i++) begin
            v.rst = (i == 0) || ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) v.iren = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                dsel   = $urandom_range(0, 2);
                v.dren = (dsel == 1);
                v.dwen = (dsel == 2);
            end
            dsel = $urandom_range(0, 15);
            if (dsel < 6)       v.rs = BUSY;
            else if (dsel < 11) v.rs = ACCESS;
            else if (dsel < 15) v.rs = FREE;
            else                v.rs = ERROR;
            v.load = $urandom;
            ia = $urandom;
            da = $urandom;
            ds = $urandom;
            e = model_expect(v, ia, da, ds);
            applyStimulus(v, ia, da, ds);
            checkOutput($sformatf("rand%0d", i), e);
            model_advance(v);
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
